// File: rtl/csr_trap_sequencer_if.sv
// CSR register-file port shared between the trap sequencer (master) and the CSR file (slave).
interface csr_trap_sequencer_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
);
  logic [CSR_AW-1:0] csr_raddr;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_we;
  logic [CSR_AW-1:0] csr_waddr;
  logic [XLEN-1:0]   csr_wdata;

  modport master (
    output csr_raddr,
    input  csr_rdata,
    output csr_we,
    output csr_waddr,
    output csr_wdata
  );

  modport slave (
    input  csr_raddr,
    output csr_rdata,
    input  csr_we,
    input  csr_waddr,
    input  csr_wdata
  );
endinterface

// File: rtl/csr_trap_sequencer.sv
// Owns the CSR write port: Zicsr writes, trap entry (ecall / trap_req) and mret sequences.
// Optional feature macro: CSR_MCAUSE_EN adds an mcause write step and makes mcause writable.
module csr_trap_sequencer #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           inst_i,
  input  logic                  inst_valid,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic                  trap_req,
  output logic                  trap_ack,
  csr_trap_sequencer_if.master  csr,
  output logic                  stall,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc
);

  localparam logic [CSR_AW-1:0] AddrMstatus = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] AddrMtvec   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] AddrMepc    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] AddrMcause  = CSR_AW'(12'h342);
  localparam logic [31:0]       InstEcall   = 32'h0000_0073;
  localparam logic [31:0]       InstMret    = 32'h3020_0073;

  typedef enum logic [2:0] {
    StIdle,
    StTrapMepc,
    StTrapMcause,
    StTrapMstatus,
    StTrapJump,
    StMretMstatus,
    StMretJump
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
`ifdef CSR_MCAUSE_EN
  logic [XLEN-1:0]   cause_q, cause_d;
`endif

  // Instruction field decode
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [4:0]        rs1_field;
  logic [CSR_AW-1:0] csr_addr;
  logic [XLEN-1:0]   operand;
  logic              is_ecall, is_mret, is_zicsr, writable;

  assign opcode    = inst_i[6:0];
  assign funct3    = inst_i[14:12];
  assign rs1_field = inst_i[19:15];
  assign csr_addr  = inst_i[20 +: CSR_AW];
  assign operand   = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_field} : rs1_data;
  assign is_ecall  = inst_valid && (inst_i == InstEcall);
  assign is_mret   = inst_valid && (inst_i == InstMret);
  assign is_zicsr  = inst_valid && (opcode == 7'b1110011) && (funct3[1:0] != 2'b00);

  // Write-permission decode for Zicsr targets
  always_comb begin
    writable = (csr_addr == AddrMstatus) || (csr_addr == AddrMtvec) || (csr_addr == AddrMepc);
`ifdef CSR_MCAUSE_EN
    writable = writable || (csr_addr == AddrMcause);
`endif
  end

  // Next-state and output decode; all outputs forced low while rst is high
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
`ifdef CSR_MCAUSE_EN
    cause_d        = cause_q;
`endif
    trap_ack       = 1'b0;
    csr.csr_raddr  = '0;
    csr.csr_we     = 1'b0;
    csr.csr_waddr  = '0;
    csr.csr_wdata  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    if (!rst) begin
      case (state_q)
        StIdle: begin
          csr.csr_raddr = csr_addr;
          if (trap_req || is_ecall) begin
            stall    = 1'b1;
            trap_ack = trap_req;
            pc_d     = pc_i;
`ifdef CSR_MCAUSE_EN
            cause_d  = trap_req ? XLEN'(32'h8000_000B) : XLEN'(32'd11);
`endif
            state_d  = StTrapMepc;
          end else if (is_mret) begin
            stall   = 1'b1;
            state_d = StMretMstatus;
          end else if (is_zicsr) begin
            csr.csr_waddr = csr_addr;
            unique case (funct3[1:0])
              2'b01:   csr.csr_wdata = operand;
              2'b10:   csr.csr_wdata = csr.csr_rdata | operand;
              default: csr.csr_wdata = csr.csr_rdata & ~operand;
            endcase
            // Set/clear with a zero rs1/uimm field is a pure read
            csr.csr_we = writable && !(funct3[1] && (rs1_field == 5'd0));
          end
        end
        StTrapMepc: begin
          stall         = 1'b1;
          csr.csr_we    = 1'b1;
          csr.csr_waddr = AddrMepc;
          csr.csr_wdata = pc_q;
`ifdef CSR_MCAUSE_EN
          state_d       = StTrapMcause;
`else
          state_d       = StTrapMstatus;
`endif
        end
`ifdef CSR_MCAUSE_EN
        StTrapMcause: begin
          stall         = 1'b1;
          csr.csr_we    = 1'b1;
          csr.csr_waddr = AddrMcause;
          csr.csr_wdata = cause_q;
          state_d       = StTrapMstatus;
        end
`endif
        StTrapMstatus: begin
          stall            = 1'b1;
          csr.csr_raddr    = AddrMstatus;
          csr.csr_we       = 1'b1;
          csr.csr_waddr    = AddrMstatus;
          csr.csr_wdata    = csr.csr_rdata;
          csr.csr_wdata[7] = csr.csr_rdata[3];  // MPIE <= MIE
          csr.csr_wdata[3] = 1'b0;              // MIE  <= 0
          state_d          = StTrapJump;
        end
        StTrapJump: begin
          csr.csr_raddr  = AddrMtvec;
          redirect_valid = 1'b1;
          redirect_pc    = {csr.csr_rdata[XLEN-1:2], 2'b00};
          state_d        = StIdle;
        end
        StMretMstatus: begin
          stall            = 1'b1;
          csr.csr_raddr    = AddrMstatus;
          csr.csr_we       = 1'b1;
          csr.csr_waddr    = AddrMstatus;
          csr.csr_wdata    = csr.csr_rdata;
          csr.csr_wdata[3] = csr.csr_rdata[7];  // MIE  <= MPIE
          csr.csr_wdata[7] = 1'b1;              // MPIE <= 1
          state_d          = StMretJump;
        end
        StMretJump: begin
          csr.csr_raddr  = AddrMepc;
          redirect_valid = 1'b1;
          redirect_pc    = csr.csr_rdata;
          state_d        = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and captured trap context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
`ifdef CSR_MCAUSE_EN
      cause_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef CSR_MCAUSE_EN
      cause_q <= cause_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer with a CSR-file model and a write scoreboard.
module tb_csr_trap_sequencer;

  localparam logic [31:0] Ecall = 32'h0000_0073;
  localparam logic [31:0] Mret  = 32'h3020_0073;
`ifdef CSR_MCAUSE_EN
  localparam int TrapMoreStalls = 3;
`else
  localparam int TrapMoreStalls = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, pc_i, rs1_data, redirect_pc;
  logic        inst_valid, trap_req, trap_ack, stall, redirect_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected CSR writes: {waddr, wdata}
  logic [43:0] exp_q[$];

  // CSR file model
  logic [31:0] m_mstatus = 32'h0;
  logic [31:0] m_mtvec   = 32'h0;
  logic [31:0] m_mepc    = 32'h0;
  logic [31:0] m_mcause  = 32'h0;

  csr_trap_sequencer_if #(.XLEN(32), .CSR_AW(12)) bus ();

  csr_trap_sequencer #(.XLEN(32), .CSR_AW(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_i         (inst_i),
    .inst_valid     (inst_valid),
    .pc_i           (pc_i),
    .rs1_data       (rs1_data),
    .trap_req       (trap_req),
    .trap_ack       (trap_ack),
    .csr            (bus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (bus.csr_raddr)
      12'h300: bus.csr_rdata = m_mstatus;
      12'h305: bus.csr_rdata = m_mtvec;
      12'h341: bus.csr_rdata = m_mepc;
      12'h342: bus.csr_rdata = m_mcause;
      default: bus.csr_rdata = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge clk) begin
    if (bus.csr_we === 1'b1) begin
      case (bus.csr_waddr)
        12'h300: m_mstatus <= bus.csr_wdata;
        12'h305: m_mtvec   <= bus.csr_wdata;
        12'h341: m_mepc    <= bus.csr_wdata;
        12'h342: m_mcause  <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected one
  always @(negedge clk) begin
    if (bus.csr_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_write: observed %h <= %h expected no write",
               bus.csr_waddr, bus.csr_wdata);
      end else begin
        logic [43:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {20'h0, bus.csr_waddr}, {20'h0, e[43:32]});
        check("wr_data", bus.csr_wdata, e[31:0]);
      end
    end
  end

  // One IDLE-cycle Zicsr instruction; starts and ends just after a rising edge
  task automatic zstep(input string tag, input logic [31:0] inst, input logic [31:0] rs1,
                       input logic exp_we, input logic [31:0] exp_data);
    inst_i     = inst;
    rs1_data   = rs1;
    inst_valid = 1'b1;
    if (exp_we) exp_q.push_back({inst[31:20], exp_data});
    @(negedge clk);
    check({tag, "_we"}, {31'h0, bus.csr_we}, {31'h0, exp_we});
    check({tag, "_stall"}, {31'h0, stall}, 32'h0);
    check({tag, "_raddr"}, {20'h0, bus.csr_raddr}, {20'h0, inst[31:20]});
    @(posedge clk); #1;
    inst_valid = 1'b0;
  endtask

  // Follow a sequence after its detect cycle until the redirect pulse
  task automatic run_to_redirect(input string tag, input logic [31:0] exp_pc,
                                 input int exp_stalls);
    int  n    = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (redirect_valid === 1'b1) begin
        seen = 1'b1;
        check({tag, "_redirect_pc"}, redirect_pc, exp_pc);
        check({tag, "_stall_at_jump"}, {31'h0, stall}, 32'h0);
      end else if (stall === 1'b1) begin
        n++;
      end
      @(posedge clk); #1;
      inst_valid = 1'b0;
      trap_req   = 1'b0;
    end
    check({tag, "_redirect_seen"}, {31'h0, seen}, 32'h1);
    check({tag, "_stall_cycles"}, n, exp_stalls);
    @(negedge clk);
    check({tag, "_redirect_pulse"}, {31'h0, redirect_valid}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; inst_i = Ecall; inst_valid = 1'b1; pc_i = 32'h0; rs1_data = 32'h0;
    trap_req = 1'b1;
    @(negedge clk);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_we", {31'h0, bus.csr_we}, 32'h0);
    check("rst_redirect", {31'h0, redirect_valid}, 32'h0);
    check("rst_ack", {31'h0, trap_ack}, 32'h0);
    check("rst_raddr", {20'h0, bus.csr_raddr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; trap_req = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'h0, stall}, 32'h0);
    check("idle_we", {31'h0, bus.csr_we}, 32'h0);
    @(posedge clk); #1;

    // Zicsr ops
    zstep("csrrw_mtvec", 32'h3050_9073, 32'h100, 1'b1, 32'h100);
    zstep("csrrs_x0", 32'h3000_2073, 32'h55, 1'b0, 32'h0);
    zstep("csrrs_mstatus", 32'h3001_2073, 32'h8, 1'b1, 32'h8);
    zstep("csrrc_mstatus", 32'h3001_B073, 32'h10, 1'b1, 32'h8);
    zstep("csrrwi_mepc", 32'h3412_D073, 32'hFFFF_FFFF, 1'b1, 32'h5);
    zstep("csrrw_mip_ro", 32'h3440_9073, 32'h1234, 1'b0, 32'h0);
`ifdef CSR_MCAUSE_EN
    zstep("csrrw_mcause", 32'h3420_9073, 32'h7, 1'b1, 32'h7);
`else
    zstep("csrrw_mcause", 32'h3420_9073, 32'h7, 1'b0, 32'h0);
`endif
    zstep("csrrw_mtvec2", 32'h3050_9073, 32'h201, 1'b1, 32'h201);

    // ecall trap entry
    inst_i = Ecall; pc_i = 32'h40; inst_valid = 1'b1;
    exp_q.push_back({12'h341, 32'h40});
`ifdef CSR_MCAUSE_EN
    exp_q.push_back({12'h342, 32'hB});
`endif
    exp_q.push_back({12'h300, 32'h80});
    @(negedge clk);
    check("ecall_stall", {31'h0, stall}, 32'h1);
    check("ecall_we", {31'h0, bus.csr_we}, 32'h0);
    check("ecall_ack", {31'h0, trap_ack}, 32'h0);
    @(posedge clk); #1;
    inst_i = 32'h3050_9073; rs1_data = 32'h999;  // ignored outside IDLE
    run_to_redirect("ecall", 32'h200, TrapMoreStalls);
    check("ecall_mepc", m_mepc, 32'h40);
    check("ecall_mstatus", m_mstatus, 32'h80);

    // mret
    zstep("csrrw_mepc", 32'h3410_9073, 32'h44, 1'b1, 32'h44);
    inst_i = Mret; inst_valid = 1'b1;
    exp_q.push_back({12'h300, 32'h88});
    @(negedge clk);
    check("mret_stall", {31'h0, stall}, 32'h1);
    check("mret_we", {31'h0, bus.csr_we}, 32'h0);
    @(posedge clk); #1;
    inst_valid = 1'b0;
    run_to_redirect("mret", 32'h44, 1);

    // trap_req collides with a csrrw to mtvec
    inst_i = 32'h3050_9073; rs1_data = 32'h999; pc_i = 32'h80; inst_valid = 1'b1;
    trap_req = 1'b1;
    exp_q.push_back({12'h341, 32'h80});
`ifdef CSR_MCAUSE_EN
    exp_q.push_back({12'h342, 32'h8000_000B});
`endif
    exp_q.push_back({12'h300, 32'h80});
    @(negedge clk);
    check("treq_ack", {31'h0, trap_ack}, 32'h1);
    check("treq_we", {31'h0, bus.csr_we}, 32'h0);
    check("treq_stall", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    trap_req = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    check("treq_ack_pulse", {31'h0, trap_ack}, 32'h0);
    @(posedge clk); #1;
    run_to_redirect("treq", 32'h200, TrapMoreStalls - 1);
    check("treq_mtvec", m_mtvec, 32'h201);
    check("treq_mepc", m_mepc, 32'h80);
`ifdef CSR_MCAUSE_EN
    check("treq_mcause", m_mcause, 32'h8000_000B);
`endif

    // Reset while in TRAP_MSTATUS
    inst_i = Ecall; pc_i = 32'h90; inst_valid = 1'b1;
    exp_q.push_back({12'h341, 32'h90});
`ifdef CSR_MCAUSE_EN
    exp_q.push_back({12'h342, 32'hB});
`endif
    @(negedge clk);
    check("rstseq_detect", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    inst_valid = 1'b0;
    for (int i = 0; i < TrapMoreStalls - 1; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rstseq_we_in_rst", {31'h0, bus.csr_we}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstseq_we", {31'h0, bus.csr_we}, 32'h0);
    check("rstseq_redirect", {31'h0, redirect_valid}, 32'h0);
    check("rstseq_stall", {31'h0, stall}, 32'h0);
    check("rstseq_mstatus", m_mstatus, 32'h80);
    check("rstseq_mepc", m_mepc, 32'h90);
    @(posedge clk); #1;
    zstep("post_rst_idle", 32'h3050_9073, 32'h300, 1'b1, 32'h300);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
